// File: rtl/bcd_digit_prep_if.sv
// ----------------------------------------------------------------------------
// bcd_digit_prep_if
//
// Bundles the conversion request and the digit outputs of bcd_digit_prep.
//
//   load        conversion request (master -> slave)
//   pc_value    8-bit binary PC value to convert (master -> slave)
//   reg_value   8-bit binary register value to convert (master -> slave)
//   pc_units    BCD units digit of pc_value (slave -> master)
//   pc_tens     BCD tens digit of pc_value (slave -> master)
//   reg_units   BCD units digit of reg_value (slave -> master)
//   reg_tens    BCD tens digit of reg_value (slave -> master)
//   pc_ovf      last converted pc_value was > 99 (slave -> master)
//   reg_ovf     last converted reg_value was > 99 (slave -> master)
//   busy        conversion in progress (slave -> master)
//   done        one-cycle pulse when new digits appear (slave -> master)
// ----------------------------------------------------------------------------
interface bcd_digit_prep_if;
   logic       load;
   logic [7:0] pc_value;
   logic [7:0] reg_value;
   logic [3:0] pc_units;
   logic [3:0] pc_tens;
   logic [3:0] reg_units;
   logic [3:0] reg_tens;
   logic       pc_ovf;
   logic       reg_ovf;
   logic       busy;
   logic       done;

   modport master (
      output load, pc_value, reg_value,
      input  pc_units, pc_tens, reg_units, reg_tens,
      input  pc_ovf, reg_ovf, busy, done
   );

   modport slave (
      input  load, pc_value, reg_value,
      output pc_units, pc_tens, reg_units, reg_tens,
      output pc_ovf, reg_ovf, busy, done
   );
endinterface

// File: rtl/bcd_digit_prep.sv
// ----------------------------------------------------------------------------
// bcd_digit_prep
//
// Converts the 8-bit PC value and the 8-bit register value to two-digit BCD
// (tens/units) for the four-digit seven-segment decoder. Both values are
// converted in parallel with an 8-step shift-add-3 (double dabble). The
// displayed digits are registered and change only when a conversion
// completes, so the decoder never sees intermediate values.
//
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous, active-high reset
//   bus     bcd_digit_prep_if.slave: load / pc_value / reg_value in,
//           digits, overflow flags, busy and done out
//
// Timing: load sampled in IDLE at edge k; shifts on edges k+1..k+8; digits,
// overflow flags and done are written at edge k+9. busy = state != IDLE.
// Values above 99 show BLANK_CODE on both digits and raise the ovf flag.
// ----------------------------------------------------------------------------
module bcd_digit_prep #(
   parameter logic [3:0] BLANK_CODE         = 4'hF,
   parameter bit         BLANK_LEADING_ZERO = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   bcd_digit_prep_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef struct packed {
      logic       ovf;
      logic [3:0] tens;
      logic [3:0] units;
   } digits_t;

   localparam logic [3:0] LAST_SHIFT = 4'd7;   // counter value on the 8th shift

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift,
   // so that doubling it carries correctly into the next decimal digit.
   function automatic logic [11:0] add3(input logic [11:0] bcd);
      logic [11:0] res;
      res = bcd;
      for (int n = 0; n < 3; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5) begin
            res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

   // Maps a finished 12-bit BCD scratch value onto the two displayed digits.
   function automatic digits_t map_digits(input logic [11:0] bcd);
      digits_t res;
      if (bcd[11:8] != 4'd0) begin
         res.ovf   = 1'b1;
         res.tens  = BLANK_CODE;
         res.units = BLANK_CODE;
      end else begin
         res.ovf   = 1'b0;
         res.tens  = bcd[7:4];
         res.units = bcd[3:0];
         // Units is never blanked, so a value of 0 still shows one "0".
         if (BLANK_LEADING_ZERO && (bcd[7:4] == 4'd0)) begin
            res.tens = BLANK_CODE;
         end
      end
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_e      state_q,     state_d;
   logic [3:0]  cnt_q,       cnt_d;

   logic [7:0]  pc_bin_q,    pc_bin_d;
   logic [7:0]  reg_bin_q,   reg_bin_d;
   logic [11:0] pc_bcd_q,    pc_bcd_d;
   logic [11:0] reg_bcd_q,   reg_bcd_d;

   logic [3:0]  pc_units_q,  pc_units_d;
   logic [3:0]  pc_tens_q,   pc_tens_d;
   logic [3:0]  reg_units_q, reg_units_d;
   logic [3:0]  reg_tens_q,  reg_tens_d;
   logic        pc_ovf_q,    pc_ovf_d;
   logic        reg_ovf_q,   reg_ovf_d;
   logic        done_q,      done_d;

   digits_t     pc_res;
   digits_t     reg_res;

   assign pc_res  = map_digits(pc_bcd_q);
   assign reg_res = map_digits(reg_bcd_q);

   // -------------------------------------------------------------------------
   // Next-state / datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned; that is what keeps this block free of inferred latches.
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_bin_d    = pc_bin_q;
      reg_bin_d   = reg_bin_q;
      pc_bcd_d    = pc_bcd_q;
      reg_bcd_d   = reg_bcd_q;
      pc_units_d  = pc_units_q;
      pc_tens_d   = pc_tens_q;
      reg_units_d = reg_units_q;
      reg_tens_d  = reg_tens_q;
      pc_ovf_d    = pc_ovf_q;
      reg_ovf_d   = reg_ovf_q;
      done_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Inputs are captured here; later changes cannot affect the result.
            if (bus.load) begin
               pc_bin_d  = bus.pc_value;
               reg_bin_d = bus.reg_value;
               pc_bcd_d  = 12'd0;
               reg_bcd_d = 12'd0;
               cnt_d     = 4'd0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            {pc_bcd_d,  pc_bin_d}  = {add3(pc_bcd_q),  pc_bin_q}  << 1;
            {reg_bcd_d, reg_bin_d} = {add3(reg_bcd_q), reg_bin_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_SHIFT) begin
               state_d = DONE;
            end
         end

         DONE: begin
            pc_units_d  = pc_res.units;
            pc_tens_d   = pc_res.tens;
            pc_ovf_d    = pc_res.ovf;
            reg_units_d = reg_res.units;
            reg_tens_d  = reg_res.tens;
            reg_ovf_d   = reg_res.ovf;
            done_d      = 1'b1;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control and output registers (synchronous reset)
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         pc_units_q  <= 4'd0;
         pc_tens_q   <= 4'd0;
         reg_units_q <= 4'd0;
         reg_tens_q  <= 4'd0;
         pc_ovf_q    <= 1'b0;
         reg_ovf_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc_units_q  <= pc_units_d;
         pc_tens_q   <= pc_tens_d;
         reg_units_q <= reg_units_d;
         reg_tens_q  <= reg_tens_d;
         pc_ovf_q    <= pc_ovf_d;
         reg_ovf_q   <= reg_ovf_d;
         done_q      <= done_d;
      end
   end

   // -------------------------------------------------------------------------
   // Shift / scratch registers
   // -------------------------------------------------------------------------
   // NOTE: these are deliberately left without reset; they are fully reloaded
   // in IDLE before any SHIFT uses them, and only read in DONE afterwards.
   always_ff @(posedge clock) begin
      pc_bin_q  <= pc_bin_d;
      reg_bin_q <= reg_bin_d;
      pc_bcd_q  <= pc_bcd_d;
      reg_bcd_q <= reg_bcd_d;
   end

   // -------------------------------------------------------------------------
   // Outputs: all driven from registers only
   // -------------------------------------------------------------------------
   assign bus.pc_units  = pc_units_q;
   assign bus.pc_tens   = pc_tens_q;
   assign bus.reg_units = reg_units_q;
   assign bus.reg_tens  = reg_tens_q;
   assign bus.pc_ovf    = pc_ovf_q;
   assign bus.reg_ovf   = reg_ovf_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

endmodule
